// File: rtl/io_port_bank.sv
// io_port_bank: multi-channel I/O port unit serving the CPU `in` and `out`
// instructions. Each channel has a one-deep input buffer and an output
// holding register with valid/ready handshakes; a small FSM sequences one
// CPU request at a time and reports completion and failure.
module io_port_bank #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                      Clock,
  input  logic                      Clear,
  input  logic                      InPortout,
  input  logic                      OutPort_enable,
  input  logic [SEL_W-1:0]          Chan_sel,
  input  logic [WIDTH-1:0]          BusMuxOut,
  output logic [WIDTH-1:0]          InPort_data,
  output logic                      Io_done,
  output logic                      Io_error,
  input  logic [CHANNELS*WIDTH-1:0] Ext_in_data,
  input  logic [CHANNELS-1:0]       Ext_in_valid,
  output logic [CHANNELS-1:0]       Ext_in_ready,
  output logic [CHANNELS*WIDTH-1:0] Ext_out_data,
  output logic [CHANNELS-1:0]       Ext_out_valid,
  input  logic [CHANNELS-1:0]       Ext_out_ready
);

  // Counter only needs to reach TIMEOUT-1; TIMEOUT=0 means wait forever.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(CHANNELS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_WAIT  = 2'd1,
    OUT_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          ch_q, ch_d;
  logic [WIDTH-1:0]          odata_q, odata_d;
  logic                      err_q, err_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CHANNELS-1:0]       in_full_q, in_full_d;
  logic [CHANNELS*WIDTH-1:0] in_buf_q, in_buf_d;
  logic [CHANNELS-1:0]       out_pend_q, out_pend_d;
  logic [CHANNELS*WIDTH-1:0] out_buf_q, out_buf_d;
  logic [WIDTH-1:0]          rd_data_q, rd_data_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;

  logic [CHANNELS-1:0]       ch_hit_s;
  logic                      sel_full_s;
  logic                      sel_pend_s;
  logic                      sel_rdy_s;
  logic [WIDTH-1:0]          sel_buf_s;
  logic                      bad_ch_s;
  logic                      timed_out_s;

  // Decode the latched channel and pick out its flags and input buffer.
  always_comb begin
    ch_hit_s  = '0;
    sel_buf_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_q == SEL_W'(i)) begin
        ch_hit_s[i] = 1'b1;
        sel_buf_s   = in_buf_q[i*WIDTH +: WIDTH];
      end else begin
        ch_hit_s[i] = 1'b0;
      end
    end
    sel_full_s  = |(in_full_q & ch_hit_s);
    sel_pend_s  = |(out_pend_q & ch_hit_s);
    sel_rdy_s   = |(Ext_out_ready & ch_hit_s);
    bad_ch_s    = ({1'b0, Chan_sel} >= CH_LIMIT);
    timed_out_s = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  end

  // Next-state logic: device-side handshakes plus the request sequencer.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    odata_d    = odata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    in_full_d  = in_full_q;
    in_buf_d   = in_buf_q;
    out_pend_d = out_pend_q;
    out_buf_d  = out_buf_q;
    rd_data_d  = rd_data_q;

    // Device side runs regardless of the FSM.
    for (int i = 0; i < CHANNELS; i++) begin
      if (Ext_in_valid[i] && !in_full_q[i]) begin
        in_full_d[i]                = 1'b1;
        in_buf_d[i*WIDTH +: WIDTH]  = Ext_in_data[i*WIDTH +: WIDTH];
      end else begin
        in_full_d[i]                = in_full_q[i];
      end
      if (out_pend_q[i] && Ext_out_ready[i]) begin
        out_pend_d[i] = 1'b0;
      end else begin
        out_pend_d[i] = out_pend_q[i];
      end
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (InPortout) begin
          ch_d    = Chan_sel;
          err_d   = bad_ch_s;
          state_d = bad_ch_s ? DONE : IN_WAIT;
        end else if (OutPort_enable) begin
          ch_d    = Chan_sel;
          odata_d = BusMuxOut;
          err_d   = bad_ch_s;
          state_d = bad_ch_s ? DONE : OUT_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      IN_WAIT: begin
        if (sel_full_s) begin
          // Ready is low on this channel, so no capture competes with the read.
          rd_data_d = sel_buf_s;
          in_full_d = in_full_d & ~ch_hit_s;
          err_d     = 1'b0;
          state_d   = DONE;
        end else if (timed_out_s) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      OUT_WAIT: begin
        if (!sel_pend_s || sel_rdy_s) begin
          // Setting the pending flag overrides the device's clear this edge.
          out_pend_d = out_pend_d | ch_hit_s;
          for (int i = 0; i < CHANNELS; i++) begin
            if (ch_hit_s[i]) begin
              out_buf_d[i*WIDTH +: WIDTH] = odata_q;
            end else begin
              out_buf_d[i*WIDTH +: WIDTH] = out_buf_q[i*WIDTH +: WIDTH];
            end
          end
          err_d   = 1'b0;
          state_d = DONE;
        end else if (timed_out_s) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        // Wait for the CPU to drop its request so a held level cannot re-trigger.
        if (!InPortout && !OutPort_enable) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d  = (state_d == DONE);
    error_d = (state_d == DONE) && err_d;
  end

  // State and data registers with synchronous clear.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      odata_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      in_full_q  <= '0;
      in_buf_q   <= '0;
      out_pend_q <= '0;
      out_buf_q  <= '0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      odata_q    <= odata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      in_full_q  <= in_full_d;
      in_buf_q   <= in_buf_d;
      out_pend_q <= out_pend_d;
      out_buf_q  <= out_buf_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign InPort_data   = rd_data_q;
  assign Io_done       = done_q;
  assign Io_error      = error_q;
  assign Ext_in_ready  = ~in_full_q;
  assign Ext_out_valid = out_pend_q;
  assign Ext_out_data  = out_buf_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Testbench for io_port_bank: directed scenarios followed by random
// transactions, checked against a transaction-level model of the channels.
module tb_io_port_bank;

  localparam int W  = 32;
  localparam int CH = 4;
  localparam int SW = 2;
  localparam int TO = 8;

  logic            Clock = 1'b0;
  logic            Clear;
  logic            InPortout, OutPort_enable;
  logic [SW-1:0]   Chan_sel;
  logic [W-1:0]    BusMuxOut;
  logic [W-1:0]    InPort_data;
  logic            Io_done, Io_error;
  logic [CH*W-1:0] Ext_in_data;
  logic [CH-1:0]   Ext_in_valid, Ext_in_ready;
  logic [CH*W-1:0] Ext_out_data;
  logic [CH-1:0]   Ext_out_valid, Ext_out_ready;

  // Second instance with fewer channels than selectable, for the bad-channel case.
  logic            b_in;
  logic [SW-1:0]   b_sel;
  logic [W-1:0]    b_rd;
  logic            b_done, b_err;
  logic [3*W-1:0]  b_out_data;
  logic [2:0]      b_in_ready, b_out_valid;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: channel contents as the CPU and devices should see them.
  logic        m_full [CH];
  logic [31:0] m_buf  [CH];
  logic        m_pend [CH];
  logic [31:0] m_obuf [CH];
  logic [31:0] m_rd;

  always #5 Clock = ~Clock;

  io_port_bank #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Clear(Clear), .InPortout(InPortout), .OutPort_enable(OutPort_enable),
    .Chan_sel(Chan_sel), .BusMuxOut(BusMuxOut), .InPort_data(InPort_data),
    .Io_done(Io_done), .Io_error(Io_error), .Ext_in_data(Ext_in_data),
    .Ext_in_valid(Ext_in_valid), .Ext_in_ready(Ext_in_ready), .Ext_out_data(Ext_out_data),
    .Ext_out_valid(Ext_out_valid), .Ext_out_ready(Ext_out_ready)
  );

  io_port_bank #(.WIDTH(W), .CHANNELS(3), .SEL_W(SW), .TIMEOUT(TO)) u_bad (
    .Clock(Clock), .Clear(Clear), .InPortout(b_in), .OutPort_enable(1'b0),
    .Chan_sel(b_sel), .BusMuxOut(32'h0), .InPort_data(b_rd),
    .Io_done(b_done), .Io_error(b_err), .Ext_in_data(96'h0),
    .Ext_in_valid(3'b000), .Ext_in_ready(b_in_ready), .Ext_out_data(b_out_data),
    .Ext_out_valid(b_out_valid), .Ext_out_ready(3'b000)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_full[i] = 1'b0; m_buf[i] = 32'h0; m_pend[i] = 1'b0; m_obuf[i] = 32'h0;
    end
    m_rd = 32'h0;
  endtask

  task automatic chk_flags(input string tag);
    logic [CH-1:0]   e_rdy, e_val;
    logic [CH*W-1:0] e_od;
    for (int i = 0; i < CH; i++) begin
      e_rdy[i] = ~m_full[i];
      e_val[i] = m_pend[i];
      e_od[i*W +: W] = m_obuf[i];
    end
    chk({tag, "_ready"}, Ext_in_ready, e_rdy);
    chk({tag, "_ovalid"}, Ext_out_valid, e_val);
    chk({tag, "_odata"}, Ext_out_data, e_od);
    chk({tag, "_rddata"}, InPort_data, m_rd);
  endtask

  task automatic prefill(input int ch, input logic [31:0] d);
    Ext_in_data[ch*W +: W] = d;
    Ext_in_valid[ch] = 1'b1;
    tick();
    Ext_in_valid[ch] = 1'b0;
    if (!m_full[ch]) begin
      m_full[ch] = 1'b1;
      m_buf[ch]  = d;
    end
  endtask

  task automatic drain(input int ch);
    Ext_out_ready[ch] = 1'b1;
    tick();
    Ext_out_ready[ch] = 1'b0;
    m_pend[ch] = 1'b0;
  endtask

  // `in` request; a = edge (after the request edge) at which the device offers
  // data, 0 = never; inject offers a new word on the first held DONE cycle.
  task automatic run_in(input int ch, input int a, input logic [31:0] d, input bit both,
                        input int hold, input bit inject, input logic [31:0] hd);
    int lat, exp_l;
    logic exp_e, was_full;
    was_full = m_full[ch];
    if (was_full) begin
      exp_l = 2; exp_e = 1'b0; m_rd = m_buf[ch]; m_full[ch] = 1'b0;
    end else if (a >= 1 && a <= TO - 1) begin
      exp_l = a + 2; exp_e = 1'b0; m_rd = d;
    end else begin
      exp_l = TO + 1; exp_e = 1'b1;
      if (a == TO) begin m_full[ch] = 1'b1; m_buf[ch] = d; end
    end
    Chan_sel = SW'(ch); InPortout = 1'b1; OutPort_enable = both; BusMuxOut = $urandom;
    Ext_in_data[ch*W +: W] = d;
    lat = 0;
    for (int e = 1; e <= TO + 4 && lat == 0; e++) begin
      Ext_in_valid[ch] = (!was_full && a != 0 && e == a + 1);
      tick();
      Ext_in_valid[ch] = 1'b0;
      if (Io_done === 1'b1) lat = e;
    end
    chk("in_latency", lat, exp_l);
    chk("in_error", Io_error, exp_e);
    for (int h = 0; h < hold; h++) begin
      if (inject && h == 0) begin
        Ext_in_data[ch*W +: W] = hd; Ext_in_valid[ch] = 1'b1;
        if (!m_full[ch]) begin m_full[ch] = 1'b1; m_buf[ch] = hd; end
      end
      tick();
      Ext_in_valid[ch] = 1'b0;
      chk("in_hold_done", Io_done, 1'b1);
    end
    InPortout = 1'b0; OutPort_enable = 1'b0;
    tick();
    chk("in_release", Io_done, 1'b0);
    chk_flags("in");
  endtask

  // `out` request; b = edge (after the request edge) at which the device
  // accepts the previously pending word, 0 = never.
  task automatic run_out(input int ch, input int b, input logic [31:0] d, input int hold);
    int lat, exp_l;
    logic exp_e, was_pend;
    was_pend = m_pend[ch];
    if (!was_pend) begin
      exp_l = 2; exp_e = 1'b0;
    end else if (b >= 1 && b <= TO) begin
      exp_l = b + 1; exp_e = 1'b0;
    end else begin
      exp_l = TO + 1; exp_e = 1'b1;
    end
    if (!exp_e) begin m_pend[ch] = 1'b1; m_obuf[ch] = d; end
    Chan_sel = SW'(ch); OutPort_enable = 1'b1; BusMuxOut = d;
    lat = 0;
    for (int e = 1; e <= TO + 4 && lat == 0; e++) begin
      Ext_out_ready[ch] = (was_pend && b != 0 && e == b + 1);
      tick();
      Ext_out_ready[ch] = 1'b0;
      if (Io_done === 1'b1) lat = e;
    end
    chk("out_latency", lat, exp_l);
    chk("out_error", Io_error, exp_e);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("out_hold_done", Io_done, 1'b1);
    end
    OutPort_enable = 1'b0;
    tick();
    chk("out_release", Io_done, 1'b0);
    chk_flags("out");
  endtask

  initial begin
    Clear = 1'b1; InPortout = 1'b0; OutPort_enable = 1'b0; Chan_sel = '0;
    BusMuxOut = '0; Ext_in_data = '0; Ext_in_valid = '0; Ext_out_ready = '0;
    b_in = 1'b0; b_sel = '0;
    model_reset();
    tick(); tick();
    Clear = 1'b0;
    tick();
    chk("reset_done", Io_done, 1'b0);
    chk("reset_error", Io_error, 1'b0);
    chk_flags("reset");

    // Basic `in` on channel 2 with data already buffered.
    prefill(2, 32'hA880_0000);
    chk("in_ready2_drop", Ext_in_ready[2], 1'b0);
    run_in(2, 0, 32'h0, 1'b0, 0, 1'b0, 32'h0);
    chk("in_basic_data", InPort_data, 32'hA880_0000);

    // Basic `out` on channel 1, then the device accepts it.
    run_out(1, 0, 32'hB080_0000, 0);
    chk("out_basic_valid", Ext_out_valid[1], 1'b1);
    drain(1);
    chk("out_drain_valid", Ext_out_valid[1], 1'b0);

    // Timeout on an empty channel, then data arriving on wait cycle 3.
    run_in(0, 0, 32'h1234_5678, 1'b0, 0, 1'b0, 32'h0);
    run_in(0, 3, 32'hCAFE_0003, 1'b0, 0, 1'b0, 32'h0);

    // Back-to-back `out` while the device accepts on the same edge.
    run_out(3, 0, 32'h3333_0001, 0);
    run_out(3, 1, 32'h3333_0002, 0);

    // Both requests high: only the read happens.
    prefill(1, 32'h0101_0101);
    run_in(1, 0, 32'h0, 1'b1, 0, 1'b0, 32'h0);

    // Bad channel on the 3-channel instance.
    b_sel = 2'd3; b_in = 1'b1;
    tick();
    chk("bad_done", b_done, 1'b1);
    chk("bad_error", b_err, 1'b1);
    b_in = 1'b0;
    tick();
    chk("bad_release", b_done, 1'b0);

    // Request held for 5 cycles after done, with new data offered meanwhile.
    prefill(0, 32'hAAAA_0000);
    run_in(0, 0, 32'h0, 1'b0, 5, 1'b1, 32'hBBBB_0000);
    chk("held_rddata", InPort_data, 32'hAAAA_0000);

    // Clear while stuck in OUT_WAIT on the pending channel 3.
    Chan_sel = 2'd3; OutPort_enable = 1'b1; BusMuxOut = 32'hDEAD_BEEF;
    tick(); tick(); tick();
    Clear = 1'b1;
    tick();
    Clear = 1'b0; OutPort_enable = 1'b0;
    model_reset();
    chk("clear_mid_done", Io_done, 1'b0);
    chk_flags("clear_mid");
    run_out(3, 0, 32'h0F0F_0F0F, 0);

    // Random mix of transactions and device activity.
    for (int n = 0; n < 60; n++) begin
      int op, ch;
      op = $urandom_range(0, 3);
      ch = $urandom_range(0, CH - 1);
      case (op)
        0: begin prefill(ch, $urandom); chk_flags("rnd_fill"); end
        1: begin drain(ch); chk_flags("rnd_drain"); end
        2: run_in(ch, $urandom_range(0, TO), $urandom, 1'b0, $urandom_range(0, 2), 1'b0, 32'h0);
        default: run_out(ch, $urandom_range(0, TO), $urandom, $urandom_range(0, 2));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
- Parametrised multi-channel I/O port unit; successor to the single in/out port pair on the datapath.
- Serves the `in` and `out` instructions over CHANNELS independent external channels, each with a valid/ready handshake.
- Sequences each CPU request with a small FSM. Reports completion to the control unit via Io_done, and failure (timeout or bad channel) via Io_error.
- Sits between the bus (BusMuxOut / bus-mux input) and the external devices.

Parameters:
WIDTH, 32, data width of bus and every channel
CHANNELS, 4, number of input and output channels (1..16)
SEL_W, 2, width of Chan_sel; 2**SEL_W >= CHANNELS
TIMEOUT, 255, max wait cycles before Io_error; 0 = wait forever

Ports:
Clock  in  1  system clock, rising edge
Clear  in  1  synchronous active-high reset
InPortout  in  1  CPU requests `in` (level, held until Io_done)
OutPort_enable  in  1  CPU requests `out` (level, held until Io_done)
Chan_sel  in  SEL_W  channel index (from IR field)
BusMuxOut  in  WIDTH  bus data for `out`
InPort_data  out  WIDTH  last value read, to bus mux
Io_done  out  1  request finished (Moore, DONE state)
Io_error  out  1  request failed; valid while Io_done=1
Ext_in_data  in  CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
Ext_in_valid  in  CHANNELS  device offers data
Ext_in_ready  out  CHANNELS  = ~in_full[i]
Ext_out_data  out  CHANNELS*WIDTH  output holding registers
Ext_out_valid  out  CHANNELS  = out_pend[i]
Ext_out_ready  in  CHANNELS  device accepts data

Behaviour:
- Reset (Clear=1 at an edge): state IDLE; in_full, out_pend, all data registers, InPort_data, counter and latches are 0. Io_done=0, Io_error=0.
- Reset mid-operation abandons the request and discards held or pending data.
- Input side, per channel, one-deep buffer:
  - Edge with Ext_in_valid[i] & ~in_full[i]: capture Ext_in_data[i] and set in_full[i].
  - This capture runs independently of the FSM.
- Output side, per channel:
  - Edge with out_pend[i] & Ext_out_ready[i]: clear out_pend[i].
- FSM states: IDLE, IN_WAIT, OUT_WAIT, DONE.
- IDLE:
  - On an edge with InPortout=1: latch Chan_sel → IN_WAIT.
  - Else if OutPort_enable=1: latch Chan_sel and BusMuxOut → OUT_WAIT. InPortout wins if both are set.
  - Latched channel >= CHANNELS: go directly to DONE with err=1.
  - The wait counter is cleared on every exit from IDLE.
- IN_WAIT:
  - If in_full[ch]: InPort_data <= buffer, clear in_full[ch], err=0 → DONE.
  - Read-clear takes priority; no new capture can occur that edge because ready was 0.
- OUT_WAIT:
  - Condition: ~out_pend[ch], or out_pend[ch] & Ext_out_ready[ch] (back-to-back allowed).
  - When met: load Ext_out_data[ch] with latched data, set out_pend[ch], err=0 → DONE.
  - Set wins over the simultaneous clear.
- Timeout:
  - In either WAIT state with the condition unmet, the counter increments each edge.
  - If TIMEOUT≠0 and counter reaches TIMEOUT-1 unmet: → DONE with err=1.
  - On timeout no register or flag is modified, and InPort_data keeps its old value.
- DONE:
  - Io_done=1 and Io_error=err.
  - Leave to IDLE only on an edge where InPortout=0 and OutPort_enable=0, so a held request never re-triggers.
- Latency, counted from the edge where IDLE samples the request:
  - Ready data: done visible after 2 edges.
  - Each additional wait cycle adds 1.
- InPort_data is stable except on a successful read.
- Ext_in_ready and Ext_out_valid are register outputs with no combinational path from inputs.

Test Plan:
- Basic `in`:
  - Stimulus: Clear, then Ext_in_valid[2]=1, data 32'hA8800000; then InPortout=1, Chan_sel=2.
  - Expected: ready[2] drops after 1 edge; Io_done at 2nd edge after request; InPort_data=32'hA8800000; ready[2] returns; Io_done clears after InPortout drops.
- Basic `out`:
  - Stimulus: OutPort_enable=1, Chan_sel=1, BusMuxOut=32'hB0800000, Ext_out_ready=0.
  - Expected: Ext_out_valid[1]=1 with data 32'hB0800000; Io_done=1, Io_error=0.
  - Then Ext_out_ready[1]=1 for 1 cycle → valid[1]=0.
- Blocking and timeout:
  - Stimulus: `in` on channel 0 with Ext_in_valid=0, TIMEOUT=8.
  - Expected: Io_done=1 and Io_error=1 after 8 wait cycles; InPort_data unchanged.
  - Repeat with data arriving at wait cycle 3 → success, no error.
- Back-to-back `out`: second `out` to channel 3 while pend[3]=1 and Ext_out_ready[3]=1 on the same edge → pend stays 1, data updated to the new value, no extra wait.
- Bad channel and priority:
  - CHANNELS=3, Chan_sel=3 → Io_error=1 at 1 edge.
  - InPortout and OutPort_enable both high → only the input read occurs; out_pend unchanged.
- Reset mid-operation and held request:
  - Clear during OUT_WAIT → all flags 0, IDLE, Io_done=0.
  - Request held 5 cycles after done → exactly one transaction.
